// File: rtl/req_ack_arbiter.sv
// Round-robin arbiter sharing one four-phase req/ack slave among N
// four-phase req/ack masters. The winning master owns the slave for the full
// return-to-zero cycle, and every output comes straight from a register.
module req_ack_arbiter #(
  parameter int N    = 4,
  parameter int IDW  = $clog2(N),
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    m_req,
  output logic [N-1:0]    m_ack,
  output logic            slv_req,
  input  logic            slv_ack,
  output logic [IDW-1:0]  gnt_id,
  output logic            busy,
  output logic [CNTW-1:0] txn_cnt
);

  // Handshake phases of the shared slave channel.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;
  localparam logic [1:0] S_REL  = 2'd3;

  // After reset the pointer sits on the highest index, so the search
  // begins at master 0.
  localparam logic [IDW-1:0]  LAST_RST = IDW'(N - 1);
  localparam logic [N-1:0]    ONE_N    = N'(1);
  localparam logic [CNTW-1:0] ONE_C    = CNTW'(1);

  logic [1:0]      state_q,   state_d;
  logic [N-1:0]    m_ack_q,   m_ack_d;
  logic            slv_req_q, slv_req_d;
  logic [IDW-1:0]  gnt_id_q,  gnt_id_d;
  logic            busy_q,    busy_d;
  logic [CNTW-1:0] txn_cnt_q, txn_cnt_d;
  logic [IDW-1:0]  last_q,    last_d;

  logic [N-1:0]    gnt_mask;
  logic            gnt_req;

  // Round-robin search: start one past the last served master and take the
  // first set request bit in increasing index order, wrapping modulo N. The
  // modulo is done on integers so that non-power-of-two N wraps correctly.
  function automatic logic [IDW-1:0] rr_pick(input logic [N-1:0]   req,
                                             input logic [IDW-1:0] last);
    logic [IDW-1:0] win;
    logic [N-1:0]   shifted;
    logic           found;
    int             idx;
    win   = last;
    found = 1'b0;
    for (int off = 1; off <= N; off++) begin
      idx     = (int'(last) + off) % N;
      shifted = req >> idx;
      if (!found && shifted[0]) begin
        win   = IDW'(idx);
        found = 1'b1;
      end
    end
    return win;
  endfunction

  // One-hot mask for the granted master. It selects that master's request
  // and drives its acknowledge. The shift avoids indexing past N-1 when N
  // is not a power of two.
  assign gnt_mask = ONE_N << gnt_id_q;
  assign gnt_req  = |(m_req & gnt_mask);

  // Next-state logic for the four-phase handshake FSM and its outputs.
  always_comb begin
    state_d   = state_q;
    m_ack_d   = m_ack_q;
    slv_req_d = slv_req_q;
    gnt_id_d  = gnt_id_q;
    busy_d    = busy_q;
    txn_cnt_d = txn_cnt_q;
    last_d    = last_q;
    case (state_q)
      S_IDLE: begin
        // Arbitration happens only here. Requests raised during a
        // transaction are simply seen again on return to IDLE.
        if (|m_req) begin
          gnt_id_d  = rr_pick(m_req, last_q);
          slv_req_d = 1'b1;
          busy_d    = 1'b1;
          state_d   = S_REQ;
        end
      end
      S_REQ: begin
        // The request stays committed even if the master withdraws, so the
        // slave always sees a complete four-phase cycle.
        if (slv_ack) begin
          m_ack_d = gnt_mask;
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        if (!gnt_req) begin
          slv_req_d = 1'b0;
          state_d   = S_REL;
        end
      end
      S_REL: begin
        if (!slv_ack) begin
          m_ack_d   = '0;
          last_d    = gnt_id_q;
          txn_cnt_d = txn_cnt_q + ONE_C;
          busy_d    = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers. Reset aborts any transaction in flight;
  // the slave is expected to be reset alongside.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      m_ack_q   <= '0;
      slv_req_q <= 1'b0;
      gnt_id_q  <= '0;
      busy_q    <= 1'b0;
      txn_cnt_q <= '0;
      last_q    <= LAST_RST;
    end else begin
      state_q   <= state_d;
      m_ack_q   <= m_ack_d;
      slv_req_q <= slv_req_d;
      gnt_id_q  <= gnt_id_d;
      busy_q    <= busy_d;
      txn_cnt_q <= txn_cnt_d;
      last_q    <= last_d;
    end
  end

  assign m_ack   = m_ack_q;
  assign slv_req = slv_req_q;
  assign gnt_id  = gnt_id_q;
  assign busy    = busy_q;
  assign txn_cnt = txn_cnt_q;

endmodule

// File: tb/tb_req_ack_arbiter.sv
// Bench for req_ack_arbiter: a per-cycle vector table for the single-request
// handshake, then hand-written sequences for pointer continuity, early
// withdrawal, mid-transaction reset, fairness and counter wrap.
// A second instance with a 2-bit counter shares the same stimulus.
module tb_req_ack_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  m_req;
  logic        slv_ack;
  logic [3:0]  m_ack;
  logic        slv_req;
  logic [1:0]  gnt_id;
  logic        busy;
  logic [15:0] txn_cnt;
  logic [3:0]  m_ack2;
  logic        slv_req2;
  logic [1:0]  gnt_id2;
  logic        busy2;
  logic [1:0]  txn_cnt2;

  int tests;
  int fails;
  int onehot_err;

  req_ack_arbiter #(.N(4), .CNTW(16)) u_dut (
    .clk(clk), .rst(rst), .m_req(m_req), .m_ack(m_ack), .slv_req(slv_req),
    .slv_ack(slv_ack), .gnt_id(gnt_id), .busy(busy), .txn_cnt(txn_cnt)
  );

  req_ack_arbiter #(.N(4), .CNTW(2)) u_dut2 (
    .clk(clk), .rst(rst), .m_req(m_req), .m_ack(m_ack2), .slv_req(slv_req2),
    .slv_ack(slv_ack), .gnt_id(gnt_id2), .busy(busy2), .txn_cnt(txn_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Acknowledge must never be multi-hot on either instance.
  always @(negedge clk) begin
    if ($countones(m_ack) > 1 || $countones(m_ack2) > 1) onehot_err++;
  end

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic        sack;
    logic [3:0]  e_ack;
    logic        e_sreq;
    logic [1:0]  e_gnt;
    logic        e_busy;
    logic [15:0] e_cnt;
  } vec_t;

  localparam int NV = 10;
  vec_t vt [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One complete transaction with an immediately responding slave and master.
  task automatic txn(input logic [3:0] reqs, input int exp_g, input int exp_cnt);
    int n;
    logic [3:0] exp_ack;
    exp_ack = 4'b0001 << exp_g;
    m_req   = reqs;
    slv_ack = 1'b0;
    n = 0;
    while (n < 20) begin
      @(posedge clk); #1;
      n++;
      if (slv_req) break;
    end
    check($sformatf("txn%0d_req_latency", exp_cnt), 32'(n), 32'd1);
    check($sformatf("txn%0d_gnt_id", exp_cnt), 32'(gnt_id), 32'(exp_g));
    check($sformatf("txn%0d_busy", exp_cnt), 32'(busy), 32'd1);
    slv_ack = 1'b1;
    @(posedge clk); #1;
    check($sformatf("txn%0d_m_ack_hi", exp_cnt), 32'(m_ack), 32'(exp_ack));
    m_req[exp_g] = 1'b0;
    @(posedge clk); #1;
    check($sformatf("txn%0d_slv_req_lo", exp_cnt), 32'(slv_req), 32'd0);
    slv_ack = 1'b0;
    @(posedge clk); #1;
    check($sformatf("txn%0d_m_ack_lo", exp_cnt), 32'(m_ack), 32'd0);
    check($sformatf("txn%0d_busy_lo", exp_cnt), 32'(busy), 32'd0);
    check($sformatf("txn%0d_cnt", exp_cnt), 32'(txn_cnt), 32'(exp_cnt));
    check($sformatf("txn%0d_cnt2", exp_cnt), 32'(txn_cnt2), 32'(exp_cnt & 3));
  endtask

  initial begin
    tests      = 0;
    fails      = 0;
    onehot_err = 0;
    rst        = 1'b1;
    m_req      = 4'h0;
    slv_ack    = 1'b0;

    //           rst   req    sack  e_ack  sreq  gnt   busy  cnt
    vt[0] = '{1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 2'd0, 1'b0, 16'd0}; // reset
    vt[1] = '{1'b0, 4'h1, 1'b0, 4'h0, 1'b1, 2'd0, 1'b1, 16'd0}; // grant
    vt[2] = '{1'b0, 4'h1, 1'b0, 4'h0, 1'b1, 2'd0, 1'b1, 16'd0}; // slave delay
    vt[3] = '{1'b0, 4'h1, 1'b1, 4'h1, 1'b1, 2'd0, 1'b1, 16'd0}; // ack
    vt[4] = '{1'b0, 4'h1, 1'b0, 4'h1, 1'b1, 2'd0, 1'b1, 16'd0}; // ack glitch
    vt[5] = '{1'b0, 4'h1, 1'b1, 4'h1, 1'b1, 2'd0, 1'b1, 16'd0};
    vt[6] = '{1'b0, 4'h0, 1'b1, 4'h1, 1'b0, 2'd0, 1'b1, 16'd0}; // release
    vt[7] = '{1'b0, 4'h0, 1'b1, 4'h1, 1'b0, 2'd0, 1'b1, 16'd0}; // wait ack lo
    vt[8] = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 2'd0, 1'b0, 16'd1}; // done
    vt[9] = '{1'b0, 4'h0, 1'b1, 4'h0, 1'b0, 2'd0, 1'b0, 16'd1}; // ack in idle

    for (int i = 0; i < NV; i++) begin
      rst     = vt[i].rst;
      m_req   = vt[i].req;
      slv_ack = vt[i].sack;
      @(posedge clk); #1;
      check($sformatf("v%0d_m_ack", i),   32'(m_ack),    32'(vt[i].e_ack));
      check($sformatf("v%0d_slv_req", i), 32'(slv_req),  32'(vt[i].e_sreq));
      check($sformatf("v%0d_gnt_id", i),  32'(gnt_id),   32'(vt[i].e_gnt));
      check($sformatf("v%0d_busy", i),    32'(busy),     32'(vt[i].e_busy));
      check($sformatf("v%0d_txn_cnt", i), 32'(txn_cnt),  32'(vt[i].e_cnt));
      check($sformatf("v%0d_txn_cnt2", i), 32'(txn_cnt2), 32'(vt[i].e_cnt[1:0]));
    end

    // Pointer continuity: 2, then 3,0,1 with masters 0,1,3 requesting.
    txn(4'b0100, 2, 2);
    txn(4'b1011, 3, 3);
    txn(4'b1011, 0, 4);
    txn(4'b1011, 1, 5);
    m_req = 4'h0;
    @(posedge clk); #1;

    // Early withdrawal by master 1 while waiting for the slave.
    m_req = 4'b0010;
    @(posedge clk); #1;
    check("wd_slv_req_up", 32'(slv_req), 32'd1);
    check("wd_gnt_id", 32'(gnt_id), 32'd1);
    m_req = 4'b0000;
    @(posedge clk); #1;
    check("wd_slv_req_held", 32'(slv_req), 32'd1);
    check("wd_no_ack_yet", 32'(m_ack), 32'd0);
    slv_ack = 1'b1;
    @(posedge clk); #1;
    check("wd_m_ack_pulse", 32'(m_ack), 32'b0010);
    check("wd_slv_req_still", 32'(slv_req), 32'd1);
    @(posedge clk); #1;
    check("wd_slv_req_fall", 32'(slv_req), 32'd0);
    slv_ack = 1'b0;
    @(posedge clk); #1;
    check("wd_m_ack_lo", 32'(m_ack), 32'd0);
    check("wd_busy_lo", 32'(busy), 32'd0);
    check("wd_cnt", 32'(txn_cnt), 32'd6);

    // Reset in ACK with m_ack=0010, then masters 0 and 2 together.
    m_req = 4'b0010;
    @(posedge clk); #1;
    slv_ack = 1'b1;
    @(posedge clk); #1;
    check("rst_pre_m_ack", 32'(m_ack), 32'b0010);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_m_ack", 32'(m_ack), 32'd0);
    check("rst_slv_req", 32'(slv_req), 32'd0);
    check("rst_gnt_id", 32'(gnt_id), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cnt", 32'(txn_cnt), 32'd0);
    rst = 1'b0;
    txn(4'b0101, 0, 1);

    // Fairness from reset with all four requesting; the 2-bit counter wraps.
    m_req = 4'h0;
    rst   = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      txn(4'b1111, k % 4, k + 1);
    end

    check("m_ack_onehot", 32'(onehot_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
